// File: rtl/fifo_rr_arbiter_pkg.sv
// rtl/fifo_rr_arbiter_pkg.sv - shared types and helpers for the round-robin FIFO arbiter
package fifo_rr_arbiter_pkg;

   typedef enum logic {ARB, GRANT} arb_state_t;

   // Index width for a source count; never narrower than one bit.
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/fifo_rr_pick.sv
// rtl/fifo_rr_pick.sv - first requesting index at or after start, wrapping around
module fifo_rr_pick
   import fifo_rr_arbiter_pkg::*;
#(
   parameter  int NUM_SRC = 4,
   localparam int IDX_W   = idx_w(NUM_SRC)
) (
   input  logic [NUM_SRC-1:0] req,
   input  logic [IDX_W-1:0]   start,
   output logic               found,
   output logic [IDX_W-1:0]   idx
);

   logic [IDX_W:0] s;

   // Walk offsets from the far end so the closest request to start wins.
   always_comb begin
      found = 1'b0;
      idx   = '0;
      s     = '0;
      for (int k = NUM_SRC - 1; k >= 0; k--) begin
         s = {1'b0, start} + (IDX_W + 1)'(k);
         if (s >= (IDX_W + 1)'(NUM_SRC)) begin
            s = s - (IDX_W + 1)'(NUM_SRC);
         end
         if (req[s[IDX_W-1:0]]) begin
            found = 1'b1;
            idx   = s[IDX_W-1:0];
         end
      end
   end

endmodule

// File: rtl/fifo_rr_arbiter.sv
// rtl/fifo_rr_arbiter.sv - round-robin burst arbiter from NUM_SRC source FIFOs into one merge FIFO
// Optional per-source push counters enabled by FIFO_RR_ARBITER_STATS_EN.
module fifo_rr_arbiter
   import fifo_rr_arbiter_pkg::*;
#(
   parameter int WIDTH     = 32,
   parameter int NUM_SRC   = 4,
   parameter int BURST_LEN = 4
`ifdef FIFO_RR_ARBITER_STATS_EN
   ,
   parameter int CNT_W     = 16
`endif
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic [NUM_SRC*WIDTH-1:0]    data_pop,
   input  logic [NUM_SRC-1:0]          valid,
   input  logic [NUM_SRC-1:0]          empty,
   output logic [NUM_SRC-1:0]          pop,
   output logic [WIDTH-1:0]            data_push,
   input  logic                        full,
   output logic                        push,
   output logic [idx_w(NUM_SRC)-1:0]   grant_id,
   output logic                        busy
`ifdef FIFO_RR_ARBITER_STATS_EN
   ,
   output logic [NUM_SRC*CNT_W-1:0]    pop_cnt
`endif
);

   localparam int IDX_W = idx_w(NUM_SRC);
   localparam int BC_W  = $clog2(BURST_LEN + 1);

   arb_state_t        state_q, state_d;
   logic [IDX_W-1:0]  grant_q, grant_d;
   logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
   logic [IDX_W-1:0]  pop_src_q, pop_src_d;
   logic [BC_W-1:0]   burst_cnt_q, burst_cnt_d;
   logic              inflight_q, inflight_d;
   logic              skid_vld_q, skid_vld_d;
   logic [WIDTH-1:0]  skid_data_q, skid_data_d;
   logic [WIDTH-1:0]  data_push_q, data_push_d;
   logic              pop_en, arrive, pick_found;
   logic [IDX_W-1:0]  pick_idx;
   logic [WIDTH-1:0]  src_word [NUM_SRC];

   for (genvar g = 0; g < NUM_SRC; g++) begin : g_unpack
      assign src_word[g] = data_pop[g*WIDTH +: WIDTH];
   end

   fifo_rr_pick #(.NUM_SRC(NUM_SRC)) u_pick (
      .req   (~empty),
      .start (rr_ptr_q),
      .found (pick_found),
      .idx   (pick_idx)
   );

   always_comb begin
      state_d     = state_q;
      grant_d     = grant_q;
      rr_ptr_d    = rr_ptr_q;
      burst_cnt_d = burst_cnt_q;
      pop         = '0;
      pop_en      = 1'b0;
      case (state_q)
         ARB: begin
            if (pick_found) begin
               grant_d     = pick_idx;
               burst_cnt_d = '0;
               state_d     = GRANT;
            end
         end
         GRANT: begin
            // Stalling pops while the skid holds a word keeps skid depth at one.
            pop_en        = !empty[grant_q] && !full && !skid_vld_q;
            pop[grant_q]  = pop_en;
            if (pop_en) begin
               burst_cnt_d = burst_cnt_q + 1'b1;
            end
            if ((pop_en && burst_cnt_q == BC_W'(BURST_LEN - 1)) || empty[grant_q]) begin
               state_d  = ARB;
               rr_ptr_d = (grant_q == IDX_W'(NUM_SRC - 1)) ? '0 : grant_q + 1'b1;
            end
         end
         default: state_d = ARB;
      endcase
      inflight_d = pop_en;
      pop_src_d  = pop_en ? grant_q : pop_src_q;
   end

   assign arrive = inflight_q && valid[pop_src_q];

   always_comb begin
      push        = 1'b0;
      data_push_d = data_push_q;
      skid_vld_d  = skid_vld_q;
      skid_data_d = skid_data_q;
      if (skid_vld_q) begin
         if (!full) begin
            push        = 1'b1;
            data_push_d = skid_data_q;
            skid_vld_d  = 1'b0;
         end
      end else if (arrive) begin
         if (!full) begin
            push        = 1'b1;
            data_push_d = src_word[pop_src_q];
         end else begin
            skid_vld_d  = 1'b1;
            skid_data_d = src_word[pop_src_q];
         end
      end
   end

   assign data_push = data_push_d;
   assign grant_id  = grant_q;
   assign busy      = (state_q == GRANT) || skid_vld_q || inflight_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ARB;
         grant_q     <= '0;
         rr_ptr_q    <= '0;
         pop_src_q   <= '0;
         burst_cnt_q <= '0;
         inflight_q  <= 1'b0;
         skid_vld_q  <= 1'b0;
         skid_data_q <= '0;
         data_push_q <= '0;
      end else begin
         state_q     <= state_d;
         grant_q     <= grant_d;
         rr_ptr_q    <= rr_ptr_d;
         pop_src_q   <= pop_src_d;
         burst_cnt_q <= burst_cnt_d;
         inflight_q  <= inflight_d;
         skid_vld_q  <= skid_vld_d;
         skid_data_q <= skid_data_d;
         data_push_q <= data_push_d;
      end
   end

`ifdef FIFO_RR_ARBITER_STATS_EN
   logic [IDX_W-1:0] skid_src_q, skid_src_d, push_src;
   logic [CNT_W-1:0] cnt_q [NUM_SRC];
   logic [CNT_W-1:0] cnt_d [NUM_SRC];

   // A skid push is credited to the source whose word was parked there.
   always_comb begin
      skid_src_d = skid_src_q;
      if (!skid_vld_q && arrive && full) begin
         skid_src_d = pop_src_q;
      end
      push_src = skid_vld_q ? skid_src_q : pop_src_q;
      for (int i = 0; i < NUM_SRC; i++) begin
         cnt_d[i] = cnt_q[i];
         if (push && push_src == IDX_W'(i) && cnt_q[i] != {CNT_W{1'b1}}) begin
            cnt_d[i] = cnt_q[i] + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         skid_src_q <= '0;
         for (int i = 0; i < NUM_SRC; i++) cnt_q[i] <= '0;
      end else begin
         skid_src_q <= skid_src_d;
         for (int i = 0; i < NUM_SRC; i++) cnt_q[i] <= cnt_d[i];
      end
   end

   for (genvar g = 0; g < NUM_SRC; g++) begin : g_cnt
      assign pop_cnt[g*CNT_W +: CNT_W] = cnt_q[g];
   end
`endif

endmodule

// File: doc/fifo_rr_arbiter.md
Name: fifo_rr_arbiter

Overview:
- Shares one downstream FIFO push port between NUM_SRC upstream FIFO pop ports.
- Grants are round-robin, with up to BURST_LEN consecutive pops per grant.
- Handles the 1-cycle upstream read latency using a 1-entry skid register, so downstream full never loses data.
- Sits between source FIFOs and a merge FIFO. It replaces the plain pop-to-push glue wherever more than one source feeds the merge FIFO.

Parameters:
- WIDTH, 32, data word width.
- NUM_SRC, 4, number of upstream FIFOs (>=2).
- BURST_LEN, 4, maximum pops per grant before rotation (>=1).
- CNT_W, 16, width of the statistics counters (optional feature only).

Ports:
- clk  input  1  clock.
- rst_n  input  1  asynchronous, active-low reset.
- data_pop  input  NUM_SRC*WIDTH  upstream read data; source i occupies bits [i*WIDTH +: WIDTH].
- valid  input  NUM_SRC  upstream read-data valid; arrives 1 cycle after pop[i].
- empty  input  NUM_SRC  upstream empty flags.
- pop  output  NUM_SRC  upstream pop strobes; one-hot or zero.
- data_push  output  WIDTH  downstream write data.
- full  input  1  downstream full.
- push  output  1  downstream push strobe.
- grant_id  output  $clog2(NUM_SRC)  currently granted source.
- busy  output  1  high if state is GRANT, or the skid is valid, or a pop is in flight.

Behaviour:
- Reset: clk is the only clock. rst_n is asynchronous and active-low. All registers clear on reset:
  - state=ARB, grant_id=0, rr_ptr=0, burst_cnt=0, skid_vld=0, inflight=0.
  - Outputs pop=0, push=0, busy=0, data_push=0.
- Reset mid-operation discards any in-flight data and the skid contents. No push is issued after reset release until a new pop completes.
- States:
  - ARB: select the first source with empty=0, searching from rr_ptr upward with wrap; rr_ptr = last grant + 1 mod NUM_SRC. Load grant_id and clear burst_cnt, then go to GRANT. If all sources are empty, stay in ARB. ARB never issues a pop.
  - GRANT: pop[grant_id] = !empty[grant_id] && !full && !skid_vld.
    - Each pop increments burst_cnt.
    - Go to ARB after the pop that makes burst_cnt==BURST_LEN.
    - Also go to ARB in any cycle where empty[grant_id]=1.
    - On leaving GRANT, rr_ptr <= grant_id+1, wrapping at NUM_SRC.
- In-flight tracking: inflight and src_d (the source index) register whether a pop occurred last cycle. Data arrival is valid[src_d] && inflight. valid from non-popped sources is ignored.
- Push path, same cycle as arrival:
  - If skid_vld: push = !full, data_push = skid_data. skid_vld clears on push.
  - Else if data arrives and !full: push=1, data_push = data_pop[src_d].
  - Else if data arrives and full: capture the data into the skid, skid_vld=1, push=0.
- Because pops are gated by !full && !skid_vld, skid and arrival never coincide, so skid depth 1 is sufficient.
- data_push holds its last value when push=0.
- Latency: pop to push is 1 cycle when not full. Grant rotation costs 1 bubble cycle (ARB).
- Throughput: BURST_LEN words per BURST_LEN+1 cycles under continuous load.
- Ordering: words from one source remain in order. Interleaving across sources happens at burst granularity only.
- Full toggling every cycle: no data is lost or duplicated; each word is pushed exactly once.

Optional Feature:
- Macro: FIFO_RR_ARBITER_STATS_EN.
- With the macro: adds output port pop_cnt, NUM_SRC*CNT_W bits.
  - Per-source saturating count of pushes, attributed to the originating source, including pushes from the skid.
  - Cleared by reset.
- Without the macro: the port and its counters do not exist. Functional behaviour is otherwise identical.

Decomposition:
- Package fifo_rr_arbiter_pkg:
  - typedef enum logic {ARB, GRANT} arb_state_t.
  - Localparam helper: index width = $clog2(NUM_SRC).
- Sub-module fifo_rr_pick: combinational. Inputs are the request vector (~empty) and the start index; outputs are the found flag and the selected index.

Test Plan:
- Single source, 10 words in src1, full=0: pop[1] for cycles 1-4, 1-cycle ARB gap, then repeats. Pushes are 10 words in order, each 1 cycle after its pop.
- All 4 sources non-empty, 8 words each, BURST_LEN=4, full=0: grant order is 0,1,2,3,0,1,2,3. The push stream is 4-word blocks per source, 32 words total.
- Source 2 pops, then full=1 is asserted on the arrival cycle: the word is captured in the skid, and pop stays 0 while full=1. When full drops, the skid word is pushed first and popping resumes. No loss.
- full toggles 1/0 every cycle, 2 sources with 6 words each: exactly 12 pushes, per-source order preserved, no pop while skid_vld=1.
- rst_n low for 1 cycle while a pop is in flight: pop=push=busy=0 immediately. After release, arbitration restarts at source 0 and the dropped word is not pushed.
- Stats (macro defined), CNT_W=4, 20 words from src0: pop_cnt[0] saturates at 15 and the other counters stay 0.
